// File: rtl/button_debouncer.sv
// button_debouncer: conditions a raw mechanical push button into a clean
// debounced level, single-cycle press/release strobes and a press-toggled level.
// Optional long-press detector is built only when BUTTON_DEBOUNCER_LONG_PRESS_EN
// is defined; otherwise btn_long is tied low but the port remains.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 32'd100000,
  parameter bit          ACTIVE_LOW        = 1'b0,
  parameter int unsigned LONG_PRESS_CYCLES = 32'd10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_toggle,
  output logic btn_long
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_CHK_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_CHK_RELEASE = 2'd3
  } state_e;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;

  // Polarity-normalised synchronized button: 1 means pressed.
  assign s = sync2_q ^ ACTIVE_LOW;

  // Two-stage synchronizer next values.
  always_comb begin
    sync1_d = push_button;
    sync2_d = sync1_q;
  end

  // Debounce FSM: a change must persist DEBOUNCE_CYCLES samples before it is accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (s) begin
          state_d = ST_CHK_PRESS;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_CHK_PRESS: begin
        if (!s) begin
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!s) begin
          state_d = ST_CHK_RELEASE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_CHK_RELEASE: begin
        if (s) begin
          state_d = ST_PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_RELEASED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Output next values derived from the upcoming state so they change on the accepting edge.
  always_comb begin
    level_d   = (state_d == ST_PRESSED) || (state_d == ST_CHK_RELEASE);
    press_d   = (state_q == ST_CHK_PRESS) && (state_d == ST_PRESSED);
    release_d = (state_q == ST_CHK_RELEASE) && (state_d == ST_RELEASED);
    toggle_d  = toggle_q ^ press_d;
  end

  // State, synchronizer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      state_q   <= ST_RELEASED;
      cnt_q     <= CNT_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_toggle  = toggle_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;

  // Saturating hold counter over the whole debounced press; a release bounce keeps the count.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_d == ST_RELEASED) begin
      hold_d = HOLD_ZERO;
    end else if (((state_q == ST_PRESSED) || (state_q == ST_CHK_RELEASE)) && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + HOLD_ONE;
      long_d = ((hold_q + HOLD_ONE) == HOLD_MAX);
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold counter and long-press strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= HOLD_ZERO;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  // Long-press threshold is only meaningful with the detector built.
  logic [31:0] unused_long_cycles;
  assign unused_long_cycles = LONG_PRESS_CYCLES;
  assign btn_long = 1'b0;
`endif

endmodule
